// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 encodings for RV64 loads/stores (F3_B .. F3_WU, F3_ILL)
//   - FSM state enum lsu_state_t
//   - size_bytes(): access size in bytes from funct3
//   - is_aligned(): natural-alignment check, also rejects the illegal funct3
package lsu_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_RMW_WR = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } lsu_state_t;

    // funct3[1:0] encodes log2(size); funct3[2] is the unsigned flag.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_bytes = 4'd1;
            2'b01:   size_bytes = 4'd2;
            2'b10:   size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

    // Returns 0 for an illegal funct3 too, so a single test decides "fault".
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] off);
        if (funct3 == F3_ILL) begin
            is_aligned = 1'b0;
        end else begin
            case (funct3[1:0])
                2'b00:   is_aligned = 1'b1;
                2'b01:   is_aligned = (off[0] == 1'b0);
                2'b10:   is_aligned = (off[1:0] == 2'b00);
                default: is_aligned = (off == 3'b000);
            endcase
        end
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane merge and load extraction.
//   base     in  64  doubleword read from memory
//   wdata    in  64  store data, valid in the low size bytes
//   off      in  3   byte offset inside the doubleword
//   funct3   in  3   access size / sign
//   merged   out 64  base with lanes off..off+size-1 replaced by wdata
//   load_val out 64  (base >> 8*off) truncated to size, sign/zero extended
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] base,
    input  logic [63:0] wdata,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    output logic [63:0] merged,
    output logic [63:0] load_val
);

    logic [5:0]  sh;
    logic [63:0] lane_mask;
    logic [63:0] pos_mask;
    logic [63:0] shifted;

    assign sh = {off, 3'b000};

    always_comb begin
        case (size_bytes(funct3))
            4'd1:    lane_mask = 64'h0000_0000_0000_00FF;
            4'd2:    lane_mask = 64'h0000_0000_0000_FFFF;
            4'd4:    lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        // Aligned accesses never cross the doubleword, so the shifted mask
        // never loses lanes off the top.
        pos_mask = lane_mask << sh;
        merged   = (base & ~pos_mask) | ((wdata << sh) & pos_mask);

        shifted = base >> sh;
        case (funct3)
            F3_B:    load_val = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    load_val = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    load_val = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   load_val = {56'd0, shifted[7:0]};
            F3_HU:   load_val = {48'd0, shifted[15:0]};
            F3_WU:   load_val = {32'd0, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage sequencer turning one RV64 load/store into
// doubleword-aligned accesses on a 64-bit data-memory port.
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_valid/o_ready           request handshake (accept on i_valid & o_ready)
//   i_we, i_funct3, i_addr,
//   i_wdata                   request fields
//   o_done, o_fault, o_rdata  one-cycle completion, fault flag, load result
//   o_busy                    stall to the hazard unit (= ~o_ready)
//   o_mem_*, o_MemRead/Write  data-memory port; all zero when not strobed
//   i_mem_rdata, i_mem_valid  combinational read data / valid from memory
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_fault,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_r_addr,
    output logic [ADDR_W-1:0] o_mem_w_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_MemRead,
    output logic              o_MemWrite,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_valid
);

    lsu_state_t        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dw_q;      // store data, then the merged doubleword
    logic [2:0]        funct3_q;
    logic              fault_q;
    logic [DATA_W-1:0] rdata_q;

    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] load_val;
    logic [ADDR_W-1:0] dw_addr;
    logic              req_ok;

    // Memory returns data combinationally, so the valid flag carries no
    // extra information for this unit.
    logic unused_mem_valid;
    assign unused_mem_valid = i_mem_valid;

    assign req_ok  = is_aligned(i_funct3, i_addr[2:0]);
    assign dw_addr = {addr_q[ADDR_W-1:3], 3'b000};

    lsu_align u_align (
        .base     (i_mem_rdata),
        .wdata    (dw_q),
        .off      (addr_q[2:0]),
        .funct3   (funct3_q),
        .merged   (merged),
        .load_val (load_val)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            dw_q     <= '0;
            funct3_q <= '0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        addr_q   <= i_addr;
                        dw_q     <= i_wdata;
                        funct3_q <= i_funct3;
                        fault_q  <= ~req_ok;
                        if (!req_ok)                state_q <= ST_DONE;
                        else if (!i_we)             state_q <= ST_LOAD;
                        else if (i_funct3 == F3_D)  state_q <= ST_WRITE;
                        else                        state_q <= ST_RMW_RD;
                    end
                end
                // The extracted value is registered straight into o_rdata so
                // it is already valid during the DONE cycle.
                ST_LOAD: begin
                    rdata_q <= load_val;
                    state_q <= ST_DONE;
                end
                // Merge against the live read so RMW_WR drives a registered,
                // stable doubleword.
                ST_RMW_RD: begin
                    dw_q    <= merged;
                    state_q <= ST_RMW_WR;
                end
                ST_RMW_WR,
                ST_WRITE: state_q <= ST_DONE;
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ready    = (state_q == ST_IDLE);
    assign o_busy     = ~o_ready;
    assign o_done     = (state_q == ST_DONE);
    assign o_fault    = o_done & fault_q;
    assign o_rdata    = rdata_q;

    assign o_MemRead  = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
    assign o_MemWrite = (state_q == ST_WRITE) || (state_q == ST_RMW_WR);

    assign o_mem_r_addr = o_MemRead  ? dw_addr : '0;
    assign o_mem_w_addr = o_MemWrite ? dw_addr : '0;
    assign o_mem_wdata  = o_MemWrite ? dw_q    : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, we;
    logic [2:0]  f3;
    logic [63:0] addr, wdata;
    logic        ready, done, fault, busy, mem_read, mem_write, mem_valid;
    logic [63:0] rdata, mem_r_addr, mem_w_addr, mem_wdata, mem_rdata;

    load_store_unit #(.ADDR_W(64), .DATA_W(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
        .i_we(we), .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
        .o_done(done), .o_rdata(rdata), .o_fault(fault), .o_busy(busy),
        .o_mem_r_addr(mem_r_addr), .o_mem_w_addr(mem_w_addr),
        .o_mem_wdata(mem_wdata), .o_MemRead(mem_read), .o_MemWrite(mem_write),
        .i_mem_rdata(mem_rdata), .i_mem_valid(mem_valid)
    );

    // ---------------- memory behind the DUT: 16 doublewords ----------------
    logic [63:0] mem [0:15];
    assign mem_rdata = mem_read ? mem[mem_r_addr[6:3]] : 64'd0;
    assign mem_valid = mem_read;
    always @(posedge clk) if (mem_write) mem[mem_w_addr[6:3]] <= mem_wdata;

    // ---------------- reference model: flat byte memory ----------------
    logic [7:0]  ref_mem [0:127];
    logic [63:0] exp_rdata;

    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = 0;
    int rd_cnt = 0, wr_cnt = 0, rd_cyc = 0, wr_cyc = 0;
    logic [63:0] rd_addr_seen, wr_addr_seen, wr_data_seen;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: strobe exclusivity and zeroed idle outputs every cycle.
    always @(negedge clk) begin
        checks++;
        if ((mem_read && mem_write) ||
            (!mem_read && mem_r_addr !== 64'd0) ||
            (!mem_write && (mem_w_addr !== 64'd0 || mem_wdata !== 64'd0))) begin
            errors++;
            $display("FAIL bus_idle_zero: rd=%0b wr=%0b r_addr=%h w_addr=%h wdata=%h required exclusive strobes and zero idle buses",
                     mem_read, mem_write, mem_r_addr, mem_w_addr, mem_wdata);
        end
        if (mem_read)  begin rd_cnt++; rd_cyc = cyc; rd_addr_seen = mem_r_addr; end
        if (mem_write) begin wr_cnt++; wr_cyc = cyc; wr_addr_seen = mem_w_addr; wr_data_seen = mem_wdata; end
    end

    function automatic int ref_size(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic bit ref_fault(input logic [2:0] f, input int a);
        return (f == 3'b111) || ((a % ref_size(f)) != 0);
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f, input int a);
        logic [63:0] v = 64'd0;
        logic [63:0] ones = '1;
        int n = ref_size(f);
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[a + i]) << (8 * i));
        if (!f[2] && n < 8 && v[8 * n - 1]) v = v | (ones << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f, input int a, input logic [63:0] d);
        for (int i = 0; i < ref_size(f); i++) ref_mem[a + i] = d[8 * i +: 8];
    endtask

    function automatic logic [63:0] ref_dw(input int idx);
        logic [63:0] v;
        for (int b = 0; b < 8; b++) v[8 * b +: 8] = ref_mem[8 * idx + b];
        return v;
    endfunction

    task automatic set_dw(input int idx, input logic [63:0] v);
        mem[idx] = v;
        for (int b = 0; b < 8; b++) ref_mem[8 * idx + b] = v[8 * b +: 8];
    endtask

    // Driver: issue one request from IDLE, wait (bounded) for o_done.
    // lat = cycle of o_done relative to the accept edge, -1 on timeout.
    task automatic do_req(input logic w, input logic [2:0] f, input int a, input logic [63:0] d,
                          output int lat, output logic flt, output logic [63:0] rd, output bit rdy_seen);
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0;
        valid = 1'b1; we = w; f3 = f; addr = 64'(a); wdata = d;
        @(posedge clk);
        #1 valid = 1'b0;
        lat = -1; flt = 1'b0; rd = rdata; rdy_seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) acc_cyc = cyc - 1;
            if (ready) rdy_seen = 1;
            if (done) begin lat = c; flt = fault; rd = rdata; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; we = 1'b0; f3 = 3'd0; addr = 64'd0; wdata = 64'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || rdata !== 64'd0 ||
            mem_read !== 1'b0 || mem_write !== 1'b0 || mem_r_addr !== 64'd0 || mem_w_addr !== 64'd0 ||
            mem_wdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_values: ready=%b busy=%b done=%b fault=%b rdata=%h rd=%b wr=%b required 1 0 0 0 0 0 0",
                     ready, busy, done, fault, rdata, mem_read, mem_write);
        end
        exp_rdata = 64'd0;
    endtask

    task automatic test_load_dw();
        int lat; logic flt; logic [63:0] rd; bit rs;
        set_dw(2, 64'h8877665544332211);
        do_req(1'b0, 3'b011, 'h10, 64'd0, lat, flt, rd, rs);
        exp_rdata = ref_load(3'b011, 'h10);
        checks++;
        if (lat !== 2 || flt !== 1'b0 || rd !== exp_rdata || rs) begin
            errors++;
            $display("FAIL ld_basic: lat=%0d fault=%b rdata=%h ready_seen=%0d required lat=2 fault=0 rdata=%h", lat, flt, rd, rs, exp_rdata);
        end
        checks++;
        if (rd_cnt !== 1 || wr_cnt !== 0 || rd_addr_seen !== 64'h10 || rd_cyc - acc_cyc !== 1) begin
            errors++;
            $display("FAIL ld_strobe: rd_cnt=%0d wr_cnt=%0d r_addr=%h rd_cycle=%0d required 1 0 10 1", rd_cnt, wr_cnt, rd_addr_seen, rd_cyc - acc_cyc);
        end
    endtask

    task automatic test_extend();
        int lat; logic flt; logic [63:0] rd; bit rs;
        logic [2:0]  fs [3] = '{3'b000, 3'b101, 3'b010};
        int          as [3] = '{'h17, 'h16, 'h14};
        logic [63:0] req [3] = '{64'hFFFFFFFFFFFFFF88, 64'h0000000000008877, 64'hFFFFFFFF88776655};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, fs[i], as[i], 64'd0, lat, flt, rd, rs);
            exp_rdata = ref_load(fs[i], as[i]);
            checks++;
            if (rd !== req[i] || rd !== exp_rdata || lat !== 2 || flt !== 1'b0) begin
                errors++;
                $display("FAIL extend_%0d: rdata=%h lat=%0d fault=%b required %h lat=2", i, rd, lat, flt, req[i]);
            end
        end
    endtask

    task automatic test_rmw_store();
        int lat; logic flt; logic [63:0] rd; bit rs;
        do_req(1'b1, 3'b001, 'h12, 64'h000000000000BEEF, lat, flt, rd, rs);
        ref_store(3'b001, 'h12, 64'hBEEF);
        checks++;
        if (lat !== 3 || flt !== 1'b0 || wr_cnt !== 1 || wr_cyc - acc_cyc !== 2 ||
            wr_addr_seen !== 64'h10 || wr_data_seen !== 64'h88776655BEEF2211 || rd !== exp_rdata) begin
            errors++;
            $display("FAIL rmw_sh: lat=%0d wr_cnt=%0d wr_cycle=%0d w_addr=%h wdata=%h rdata=%h required 3 1 2 10 88776655beef2211 %h",
                     lat, wr_cnt, wr_cyc - acc_cyc, wr_addr_seen, wr_data_seen, rd, exp_rdata);
        end
        do_req(1'b0, 3'b011, 'h10, 64'd0, lat, flt, rd, rs);
        exp_rdata = ref_load(3'b011, 'h10);
        checks++;
        if (rd !== 64'h88776655BEEF2211 || rd !== exp_rdata) begin
            errors++;
            $display("FAIL rmw_readback: rdata=%h required 88776655beef2211", rd);
        end
    endtask

    task automatic test_fault();
        int lat; logic flt; logic [63:0] rd; bit rs;
        logic [2:0] fs [2] = '{3'b010, 3'b111};
        logic       ws [2] = '{1'b1, 1'b0};
        int         as [2] = '{'h13, 'h10};
        for (int i = 0; i < 2; i++) begin
            do_req(ws[i], fs[i], as[i], 64'hDEADBEEFCAFEF00D, lat, flt, rd, rs);
            checks++;
            if (lat !== 1 || flt !== 1'b1 || rd_cnt !== 0 || wr_cnt !== 0 || rd !== exp_rdata) begin
                errors++;
                $display("FAIL fault_%0d: lat=%0d fault=%b rd_cnt=%0d wr_cnt=%0d rdata=%h required 1 1 0 0 %h",
                         i, lat, flt, rd_cnt, wr_cnt, rd, exp_rdata);
            end
        end
        checks++;
        if (mem[2] !== ref_dw(2)) begin
            errors++;
            $display("FAIL fault_mem: mem=%h required %h", mem[2], ref_dw(2));
        end
    endtask

    task automatic test_reset_mid_rmw();
        bit rd_phase, idle_after;
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0;
        valid = 1'b1; we = 1'b1; f3 = 3'b000; addr = 64'h10; wdata = 64'h55;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        rd_phase = mem_read;
        rst = 1'b1;
        @(negedge clk);
        idle_after = ready && !mem_write && !mem_read;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        exp_rdata = 64'd0;
        checks++;
        if (!rd_phase || !idle_after || wr_cnt !== 0 || mem[2] !== ref_dw(2) || rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_rmw: in_rmw_rd=%0d idle_after=%0d wr_cnt=%0d mem=%h rdata=%h required 1 1 0 %h 0",
                     rd_phase, idle_after, wr_cnt, mem[2], rdata, ref_dw(2));
        end
    endtask

    task automatic test_back_to_back();
        int c_sd = -1, c_ld = -1;
        bit ready_early = 0;
        logic [63:0] d = {$urandom, $urandom};
        logic [63:0] rd = 64'd0;
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0;
        valid = 1'b1; we = 1'b1; f3 = 3'b011; addr = 64'h28; wdata = d;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c_sd < 0 && ready) ready_early = 1;
            if (c_sd >= 0 && c == c_sd + 2) valid = 1'b0;
            if (done && c_sd < 0) begin c_sd = c; we = 1'b0; end
            else if (done) begin c_ld = c; rd = rdata; break; end
        end
        valid = 1'b0;
        ref_store(3'b011, 'h28, d);
        exp_rdata = ref_load(3'b011, 'h28);
        checks++;
        if (c_sd !== 2 || c_ld !== 5 || ready_early || rd !== exp_rdata || rd_cnt !== 1 || wr_cnt !== 1) begin
            errors++;
            $display("FAIL back_to_back: sd_done=%0d ld_done=%0d ready_early=%0d rdata=%h rd_cnt=%0d wr_cnt=%0d required 2 5 0 %h 1 1",
                     c_sd, c_ld, ready_early, rd, rd_cnt, wr_cnt, exp_rdata);
        end
    endtask

    task automatic test_random();
        int lat, a, sz, e_lat, e_rd, e_wr; logic flt; logic [63:0] rd, d; bit rs, e_flt;
        logic w; logic [2:0] f;
        for (int n = 0; n < 60; n++) begin
            w  = 1'($urandom_range(0, 1));
            f  = 3'($urandom_range(0, 7));
            sz = ref_size(f);
            a  = $urandom_range(0, 127);
            if ($urandom_range(0, 3) != 0) a = a - (a % sz);
            d  = {$urandom, $urandom};
            do_req(w, f, a, d, lat, flt, rd, rs);
            e_flt = ref_fault(f, a);
            e_lat = e_flt ? 1 : (!w ? 2 : (sz == 8 ? 2 : 3));
            e_rd  = (e_flt || (w && sz == 8)) ? 0 : 1;
            e_wr  = (w && !e_flt) ? 1 : 0;
            if (!e_flt && !w) exp_rdata = ref_load(f, a);
            if (!e_flt && w)  ref_store(f, a, d);
            checks++;
            if (lat !== e_lat || flt !== e_flt || rd !== exp_rdata || rd_cnt !== e_rd || wr_cnt !== e_wr ||
                (e_wr == 1 && wr_cyc - acc_cyc !== e_lat - 1) || rs) begin
                errors++;
                $display("FAIL random_%0d: we=%b f3=%0d addr=%h lat=%0d fault=%b rdata=%h rd=%0d wr=%0d required lat=%0d fault=%b rdata=%h rd=%0d wr=%0d",
                         n, w, f, a, lat, flt, rd, rd_cnt, wr_cnt, e_lat, e_flt, exp_rdata, e_rd, e_wr);
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[i] !== ref_dw(i)) begin
                errors++;
                $display("FAIL random_mem_%0d: mem=%h required %h", i, mem[i], ref_dw(i));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) set_dw(i, {$urandom, $urandom});
        test_reset();
        test_load_dw();
        test_extend();
        test_rmw_store();
        test_fault();
        test_reset_mid_rmw();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
